// File: rtl/inst_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer.
package inst_sequencer_pkg;

   // 2'd3 is not a legal state; the FSM steers it back to FETCH.
   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_EXEC0   = 2'd1,
      ST_EXEC1   = 2'd2,
      ST_ILLEGAL = 2'd3
   } state_e;

   // Opcode 8'h00 decodes to no register, memory or carry write.
   localparam logic [7:0] BUBBLE = 8'h00;

   // Bit 7 marks the memory/jump ops that need a second exec cycle.
   function automatic logic is_two_cycle(input logic [7:0] op);
      return op[7];
   endfunction

endpackage

// File: rtl/inst_sequencer_if.sv
// Instruction-memory fetch bus between the sequencer (master) and imem (slave).
interface inst_sequencer_if #(
   parameter int PC_W = 16
) ();
   logic [PC_W-1:0] imem_addr;
   logic            imem_req;
   logic [7:0]      imem_rdata;
   logic            imem_valid;

   modport master (output imem_addr, imem_req, input imem_rdata, imem_valid);
   modport slave  (input imem_addr, imem_req, output imem_rdata, imem_valid);
endinterface

// File: rtl/inst_sequencer_pc_unit.sv
// Program counter: load has priority over increment; otherwise hold.
module pc_unit #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            inc_i,
   input  logic            load_i,
   input  logic [PC_W-1:0] load_val_i,
   output logic [PC_W-1:0] pc_o
);

   logic [PC_W-1:0] pc_q, pc_d;

   // Next PC; the increment wraps naturally at 2^PC_W-1.
   always_comb begin
      pc_d = pc_q;
      if (load_i)     pc_d = load_val_i;
      else if (inc_i) pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
   end

   // PC register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/inst_sequencer.sv
// Fetch/exec sequencer feeding the control decoder: FSM, IR, cycle, carry.
module inst_sequencer
   import inst_sequencer_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   inst_sequencer_if.master    imem,
   input  logic                stall_i,
   input  logic                j_i,
   input  logic [PC_W-1:0]     jump_target_i,
   input  logic                wc_i,
   input  logic                alu_carry_i,
   output logic [7:0]          inst_o,
   output logic                cycle_o,
   output logic                carry_o,
   output logic                inst_valid_o,
   output logic [PC_W-1:0]     pc_o
);

   state_e      state_q, state_d;
   logic [7:0]  ir_q, ir_d;
   logic        cycle_q, cycle_d;
   logic        carry_q, carry_d;
   logic        pc_inc, pc_load, commit;
   logic [PC_W-1:0] pc;

   pc_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc_i      (pc_inc),
      .load_i     (pc_load),
      .load_val_i (jump_target_i),
      .pc_o       (pc)
   );

   // Next-state and commit logic; stall freezes every exec-cycle side effect.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cycle_d = cycle_q;
      carry_d = carry_q;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (imem.imem_valid) begin
               ir_d    = imem.imem_rdata;
               pc_inc  = 1'b1;
               state_d = ST_EXEC0;
            end
         end
         ST_EXEC0: begin
            if (!stall_i) begin
               if (is_two_cycle(ir_q)) begin
                  cycle_d = 1'b1;
                  state_d = ST_EXEC1;
               end else begin
                  commit  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_EXEC1: begin
            if (!stall_i) begin
               commit  = 1'b1;
               cycle_d = 1'b0;
               pc_load = j_i;
               state_d = ST_FETCH;
            end
         end
         default: begin
            cycle_d = 1'b0;
            state_d = ST_FETCH;
         end
      endcase
      if (commit && wc_i) carry_d = alu_carry_i;
   end

   // State, IR, cycle and carry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         ir_q    <= BUBBLE;
         cycle_q <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cycle_q <= cycle_d;
         carry_q <= carry_d;
      end
   end

   assign inst_valid_o   = (state_q == ST_EXEC0) || (state_q == ST_EXEC1);
   assign inst_o         = inst_valid_o ? ir_q : BUBBLE;
   assign cycle_o        = cycle_q;
   assign carry_o        = carry_q;
   assign pc_o           = pc;
   assign imem.imem_req  = (state_q == ST_FETCH);
   assign imem.imem_addr = pc;

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed bench for inst_sequencer: one task per scenario, inline checks.
module tb_inst_sequencer;

   localparam int              PC_W     = 16;
   localparam logic [PC_W-1:0] RESET_PC = 16'h0100;

   logic            clk;
   logic            rst_n;
   logic            stall, j, wc, ac;
   logic [PC_W-1:0] jt;
   logic [7:0]      inst;
   logic            cycle, carry, inst_valid;
   logic [PC_W-1:0] pc;

   int n_checks = 0;
   int n_fail   = 0;

   inst_sequencer_if #(.PC_W(PC_W)) ifc ();

   inst_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem          (ifc),
      .stall_i       (stall),
      .j_i           (j),
      .jump_target_i (jt),
      .wc_i          (wc),
      .alu_carry_i   (ac),
      .inst_o        (inst),
      .cycle_o       (cycle),
      .carry_o       (carry),
      .inst_valid_o  (inst_valid),
      .pc_o          (pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock; return on the falling edge for sampling/driving.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      n_checks++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL rst_pc got %h exp %h", pc, RESET_PC); end
      n_checks++; if (inst !== 8'h00) begin n_fail++; $display("FAIL rst_inst got %h exp 00", inst); end
      n_checks++; if (cycle !== 1'b0) begin n_fail++; $display("FAIL rst_cycle got %b exp 0", cycle); end
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL rst_carry got %b exp 0", carry); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ivalid got %b exp 0", inst_valid); end
      rst_n = 1'b1;
      tick();
      n_checks++; if (ifc.imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req got %b exp 1", ifc.imem_req); end
      n_checks++; if (ifc.imem_addr !== RESET_PC) begin n_fail++; $display("FAIL rst_addr got %h exp %h", ifc.imem_addr, RESET_PC); end
   endtask

   task automatic test_fetch_wait();
      ifc.imem_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_checks++; if (ifc.imem_req !== 1'b1 || inst !== 8'h00 || pc !== 16'h0100) begin
            n_fail++; $display("FAIL wait_hold req %b inst %h pc %h exp 1 00 0100", ifc.imem_req, inst, pc); end
      end
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h41;
      tick();
      ifc.imem_valid = 1'b0;
      n_checks++; if (inst !== 8'h41 || cycle !== 1'b0 || inst_valid !== 1'b1) begin
         n_fail++; $display("FAIL f41_exec inst %h cyc %b iv %b exp 41 0 1", inst, cycle, inst_valid); end
      n_checks++; if (pc !== 16'h0101 || ifc.imem_req !== 1'b0) begin
         n_fail++; $display("FAIL f41_pc pc %h req %b exp 0101 0", pc, ifc.imem_req); end
      tick();
      n_checks++; if (inst !== 8'h00 || ifc.imem_req !== 1'b1 || inst_valid !== 1'b0 || ifc.imem_addr !== 16'h0101) begin
         n_fail++; $display("FAIL f41_back inst %h req %b iv %b addr %h exp 00 1 0 0101", inst, ifc.imem_req, inst_valid, ifc.imem_addr); end
   endtask

   task automatic test_stall();
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h80;
      tick();
      ifc.imem_valid = 1'b0;
      n_checks++; if (inst !== 8'h80 || cycle !== 1'b0 || pc !== 16'h0102) begin
         n_fail++; $display("FAIL st_e0 inst %h cyc %b pc %h exp 80 0 0102", inst, cycle, pc); end
      tick();
      n_checks++; if (cycle !== 1'b1 || inst !== 8'h80) begin
         n_fail++; $display("FAIL st_e1 cyc %b inst %h exp 1 80", cycle, inst); end
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (cycle !== 1'b1 || inst !== 8'h80 || inst_valid !== 1'b1 || ifc.imem_req !== 1'b0) begin
            n_fail++; $display("FAIL st_hold%0d cyc %b inst %h iv %b req %b exp 1 80 1 0", i, cycle, inst, inst_valid, ifc.imem_req); end
      end
      stall = 1'b0;
      tick();
      n_checks++; if (cycle !== 1'b0 || inst !== 8'h00 || ifc.imem_req !== 1'b1 || ifc.imem_addr !== 16'h0102) begin
         n_fail++; $display("FAIL st_done cyc %b inst %h req %b addr %h exp 0 00 1 0102", cycle, inst, ifc.imem_req, ifc.imem_addr); end
   endtask

   task automatic test_jump();
      j = 1'b1; jt = 16'h1234;
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'hE0;
      tick();
      ifc.imem_valid = 1'b0;
      tick();
      // J held through EXEC0 must not have loaded the PC.
      n_checks++; if (pc !== 16'h0103 || cycle !== 1'b1) begin
         n_fail++; $display("FAIL jmp_e0_ign pc %h cyc %b exp 0103 1", pc, cycle); end
      tick();
      n_checks++; if (ifc.imem_addr !== 16'h1234 || ifc.imem_req !== 1'b1) begin
         n_fail++; $display("FAIL jmp_taken addr %h req %b exp 1234 1", ifc.imem_addr, ifc.imem_req); end
      j = 1'b0;
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'hE0;
      tick();
      ifc.imem_valid = 1'b0;
      tick(); tick();
      n_checks++; if (ifc.imem_addr !== 16'h1235) begin
         n_fail++; $display("FAIL jmp_not addr %h exp 1235", ifc.imem_addr); end
   endtask

   task automatic test_carry_wrap();
      wc = 1'b1; ac = 1'b1; ifc.imem_valid = 1'b0;
      tick();
      n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL cy_fetch_ign got %b exp 0", carry); end
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h50;
      tick();
      ifc.imem_valid = 1'b0; stall = 1'b1;
      tick();
      n_checks++; if (carry !== 1'b0 || inst !== 8'h50) begin
         n_fail++; $display("FAIL cy_stall_ign carry %b inst %h exp 0 50", carry, inst); end
      stall = 1'b0;
      tick();
      n_checks++; if (carry !== 1'b1 || ifc.imem_req !== 1'b1) begin
         n_fail++; $display("FAIL cy_set carry %b req %b exp 1 1", carry, ifc.imem_req); end
      wc = 1'b0; ac = 1'b0;
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h10;
      tick();
      ifc.imem_valid = 1'b0;
      tick();
      n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL cy_keep got %b exp 1", carry); end
      // Jump to the top of the address space, then fetch across the wrap.
      j = 1'b1; jt = 16'hFFFF;
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h80;
      tick();
      ifc.imem_valid = 1'b0;
      tick(); tick();
      j = 1'b0;
      n_checks++; if (ifc.imem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_jmp addr %h exp ffff", ifc.imem_addr); end
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h00;
      tick();
      ifc.imem_valid = 1'b0;
      n_checks++; if (pc !== 16'h0000 || inst_valid !== 1'b1) begin
         n_fail++; $display("FAIL wrap_pc pc %h iv %b exp 0000 1", pc, inst_valid); end
      tick();
      n_checks++; if (ifc.imem_addr !== 16'h0000 || ifc.imem_req !== 1'b1 || carry !== 1'b1) begin
         n_fail++; $display("FAIL wrap_back addr %h req %b carry %b exp 0000 1 1", ifc.imem_addr, ifc.imem_req, carry); end
   endtask

   task automatic test_async_reset();
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h80;
      tick();
      ifc.imem_valid = 1'b0;
      tick();
      n_checks++; if (cycle !== 1'b1 || inst !== 8'h80) begin
         n_fail++; $display("FAIL ar_pre cyc %b inst %h exp 1 80", cycle, inst); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (pc !== RESET_PC || inst !== 8'h00 || cycle !== 1'b0) begin
         n_fail++; $display("FAIL ar_now pc %h inst %h cyc %b exp %h 00 0", pc, inst, cycle, RESET_PC); end
      n_checks++; if (carry !== 1'b0 || inst_valid !== 1'b0 || ifc.imem_req !== 1'b1) begin
         n_fail++; $display("FAIL ar_flags carry %b iv %b req %b exp 0 0 1", carry, inst_valid, ifc.imem_req); end
      @(negedge clk);
      rst_n = 1'b1;
      ifc.imem_valid = 1'b1; ifc.imem_rdata = 8'h3C;
      tick();
      ifc.imem_valid = 1'b0;
      n_checks++; if (inst !== 8'h3C || pc !== 16'h0101) begin
         n_fail++; $display("FAIL ar_refetch inst %h pc %h exp 3c 0101", inst, pc); end
   endtask

   initial begin
      stall = 1'b0; j = 1'b0; jt = '0; wc = 1'b0; ac = 1'b0;
      ifc.imem_valid = 1'b0; ifc.imem_rdata = 8'h00;
      test_reset();
      test_fetch_wait();
      test_stall();
      test_jump();
      test_carry_wrap();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
